pipe_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage RISC-V core. It works alongside the forwarding unit and resolves the hazards that forwarding cannot:
- load-use stalls;
- taken-branch flushes;
- instruction-fetch bubbles;
- data-memory wait freezes;
- debug halt/drain/resume.

It drives the PC and pipeline-register enable/flush lines and keeps stall/flush performance counters.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/pipe_ctrl_perf_cnt.sv | 15 +
 rtl/pipe_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types for the pipeline sequencer of the 5-stage core
package riscv_pkg;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} ctrl_state_t;
  typedef struct packed {
    logic pc_en;
    logic pc_sel_branch;
    logic IFID_en;
    logic IFID_flush;
    logic IDEX_en;
    logic IDEX_flush;
    logic EXMEM_en;
    logic MEMWB_en;
  } PIPE_CTRL;
  typedef struct packed {
    logic [4:0] ID_rs1;
    logic [4:0] ID_rs2;
    logic       ID_use_rs1;
    logic       ID_use_rs2;
    logic [4:0] EX_rd;
    logic       EX_MemRead;
  } HAZ_in;
  localparam PIPE_CTRL CTRL_RUN = PIPE_CTRL'(8'b1010_1011);
  localparam PIPE_CTRL CTRL_BOOT = PIPE_CTRL'(8'b0001_0100);
  function automatic logic load_use(HAZ_in h);
    return h.EX_MemRead && h.EX_rd != 5'd0 &&
           ((h.ID_use_rs1 && h.ID_rs1 == h.EX_rd) || (h.ID_use_rs2 && h.ID_rs2 == h.EX_rd));
  endfunction
endpackage

// File: rtl/pipe_ctrl_perf_cnt.sv
// perf_cnt: saturating event counter
module perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  assign cnt_o = cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/debug sequencer driving PC and pipeline-register controls
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int DMEM_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_MemRead,
  input  logic             EX_branch_taken,
  input  logic             imem_valid,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume_req,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             IFID_en,
  output logic             IFID_flush,
  output logic             IDEX_en,
  output logic             IDEX_flush,
  output logic             EXMEM_en,
  output logic             MEMWB_en,
  output logic             halted,
  output logic             dmem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam int TW = $clog2(DMEM_TIMEOUT + 2);
  ctrl_state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [TW-1:0] wait_q, wait_d;
  logic err_q, err_d, stall_inc, flush_inc, freeze;
  PIPE_CTRL c;
  HAZ_in haz;
  assign haz = '{ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_rd, EX_MemRead};
  assign freeze = (state_q == RUN || state_q == DRAIN) && dmem_req && !dmem_ready;
  always_comb begin
    c = '0;
    state_d = state_q;
    drain_d = drain_q;
    wait_d = '0;
    err_d = err_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (freeze) begin
      stall_inc = 1'b1;
      wait_d = wait_q + 1'b1;
      if (wait_d == TW'(DMEM_TIMEOUT)) begin
        err_d = 1'b1;
        state_d = HALTED;
      end
    end else if (state_q == BOOT) begin
      c = CTRL_BOOT;
      state_d = RUN;
    end else if (state_q == RUN) begin
      c = CTRL_RUN;
      if (EX_branch_taken) begin
        c.pc_sel_branch = 1'b1;
        c.IFID_flush = 1'b1;
        c.IDEX_flush = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use(haz)) begin
        c.pc_en = 1'b0;
        c.IFID_en = 1'b0;
        c.IDEX_flush = 1'b1;
        stall_inc = 1'b1;
      end else if (!imem_valid) begin
        c.pc_en = 1'b0;
        c.IFID_flush = 1'b1;
        stall_inc = 1'b1;
      end
      if (halt_req) begin
        state_d = DRAIN;
        drain_d = DW'(DRAIN_CYCLES);
      end
    end else if (state_q == DRAIN) begin
      // A taken branch loads its target so the PC holds the resume point
      c = CTRL_RUN;
      c.pc_en = EX_branch_taken;
      c.pc_sel_branch = EX_branch_taken;
      c.IFID_flush = 1'b1;
      c.IDEX_flush = EX_branch_taken;
      drain_d = drain_q == '0 ? '0 : drain_q - 1'b1;
      if (drain_q <= DW'(1)) state_d = HALTED;
    end else if (resume_req && !err_q) begin
      state_d = RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BOOT;
      drain_q <= '0;
      wait_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      wait_q <= wait_d;
      err_q <= err_d;
    end
  assign {pc_en, pc_sel_branch, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_en} = c;
  assign halted = state_q == HALTED;
  assign dmem_timeout_err = err_q;
  perf_cnt #(.W(CNT_W)) u_stall (.clk(clk), .rst_n(rst_n), .inc_i(stall_inc), .cnt_o(stall_cnt));
  perf_cnt #(.W(CNT_W)) u_flush (.clk(clk), .rst_n(rst_n), .inc_i(flush_inc), .cnt_o(flush_cnt));
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenario checks of pipe_ctrl
module tb_pipe_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic ID_use_rs1, ID_use_rs2, EX_MemRead, EX_branch_taken, imem_valid, dmem_req, dmem_ready, halt_req, resume_req;
  logic pc_en, pc_sel_branch, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_en, halted, dmem_timeout_err;
  logic [31:0] stall_cnt, flush_cnt;
  logic n_pc_en, n_pc_sel_branch, n_IFID_en, n_IFID_flush, n_IDEX_en, n_IDEX_flush, n_EXMEM_en, n_MEMWB_en, n_halted, n_err;
  logic [1:0] n_stall, n_flush;
  logic [7:0] ctl;
  int total = 0, bad = 0;
  assign ctl = {pc_en, pc_sel_branch, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_en, MEMWB_en};
  always #5 clk = ~clk;

  pipe_ctrl #(.DRAIN_CYCLES(4), .DMEM_TIMEOUT(4), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_branch_taken(EX_branch_taken), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req), .resume_req(resume_req),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .IFID_en(IFID_en), .IFID_flush(IFID_flush),
    .IDEX_en(IDEX_en), .IDEX_flush(IDEX_flush), .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
    .halted(halted), .dmem_timeout_err(dmem_timeout_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipe_ctrl #(.DRAIN_CYCLES(4), .DMEM_TIMEOUT(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_rd(EX_rd), .EX_MemRead(EX_MemRead), .EX_branch_taken(EX_branch_taken), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req), .resume_req(resume_req),
    .pc_en(n_pc_en), .pc_sel_branch(n_pc_sel_branch), .IFID_en(n_IFID_en), .IFID_flush(n_IFID_flush),
    .IDEX_en(n_IDEX_en), .IDEX_flush(n_IDEX_flush), .EXMEM_en(n_EXMEM_en), .MEMWB_en(n_MEMWB_en),
    .halted(n_halted), .dmem_timeout_err(n_err), .stall_cnt(n_stall), .flush_cnt(n_flush));

  task idle;
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; EX_rd = 5'd0;
    ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0; EX_MemRead = 1'b0; EX_branch_taken = 1'b0;
    imem_valid = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0; resume_req = 1'b0;
  endtask

  task cyc;
    @(posedge clk);
    #2;
  endtask

  task test_reset;
    idle;
    rst_n = 1'b0;
    #3;
    total++; if (ctl !== 8'h14) begin bad++; $display("FAIL reset_ctl got %h want 14", ctl); end
    total++; if ({halted, dmem_timeout_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b want 00", {halted, dmem_timeout_err}); end
    total++; if (stall_cnt !== 0 || flush_cnt !== 0) begin bad++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    cyc;
    rst_n = 1'b1;
    #1;
    total++; if (ctl !== 8'h14) begin bad++; $display("FAIL boot_ctl got %h want 14", ctl); end
    cyc;
    #1;
    total++; if (ctl !== 8'hAB) begin bad++; $display("FAIL run_ctl got %h want ab", ctl); end
  endtask

  task test_load_use;
    EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
    #1;
    total++; if (ctl !== 8'h0F) begin bad++; $display("FAIL lu_rs1_ctl got %h want 0f", ctl); end
    cyc;
    idle;
    #1;
    total++; if (ctl !== 8'hAB || stall_cnt !== 1) begin bad++; $display("FAIL lu_one_cycle got %h/%0d want ab/1", ctl, stall_cnt); end
    EX_MemRead = 1'b1; EX_rd = 5'd7; ID_rs2 = 5'd7; ID_use_rs2 = 1'b1;
    #1;
    total++; if (ctl !== 8'h0F) begin bad++; $display("FAIL lu_rs2_ctl got %h want 0f", ctl); end
    cyc;
    ID_use_rs2 = 1'b0; ID_rs1 = 5'd3; ID_use_rs1 = 1'b1;
    #1;
    total++; if (ctl !== 8'hAB || stall_cnt !== 2) begin bad++; $display("FAIL lu_unused_src got %h/%0d want ab/2", ctl, stall_cnt); end
    cyc;
    idle;
  endtask

  task test_x0;
    EX_MemRead = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_use_rs1 = 1'b1; ID_rs2 = 5'd0; ID_use_rs2 = 1'b1;
    #1;
    total++; if (ctl !== 8'hAB) begin bad++; $display("FAIL x0_ctl got %h want ab", ctl); end
    cyc;
    idle;
    #1;
    total++; if (stall_cnt !== 2) begin bad++; $display("FAIL x0_stall got %0d want 2", stall_cnt); end
  endtask

  task test_branch;
    EX_branch_taken = 1'b1; EX_MemRead = 1'b1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1'b1;
    #1;
    total++; if (ctl !== 8'hFF) begin bad++; $display("FAIL br_ctl got %h want ff", ctl); end
    cyc;
    idle;
    #1;
    total++; if (flush_cnt !== 1 || stall_cnt !== 2) begin bad++; $display("FAIL br_cnt got %0d/%0d want 1/2", flush_cnt, stall_cnt); end
  endtask

  task test_bubble;
    imem_valid = 1'b0;
    #1;
    total++; if (ctl !== 8'h3B) begin bad++; $display("FAIL bubble_ctl got %h want 3b", ctl); end
    cyc;
    idle;
    #1;
    total++; if (stall_cnt !== 3) begin bad++; $display("FAIL bubble_stall got %0d want 3", stall_cnt); end
  endtask

  task test_freeze;
    dmem_req = 1'b1; EX_branch_taken = 1'b1; halt_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== 8'h00) begin bad++; $display("FAIL freeze_ctl[%0d] got %h want 00", i, ctl); end
      cyc;
    end
    dmem_ready = 1'b1; halt_req = 1'b0;
    #1;
    total++; if (ctl !== 8'hFF || stall_cnt !== 6) begin bad++; $display("FAIL freeze_release got %h/%0d want ff/6", ctl, stall_cnt); end
    total++; if (n_stall !== 2'd3) begin bad++; $display("FAIL stall_saturate got %0d want 3", n_stall); end
    cyc;
    idle;
    #1;
    total++; if (ctl !== 8'hAB || flush_cnt !== 2) begin bad++; $display("FAIL freeze_halt_ignored got %h/%0d want ab/2", ctl, flush_cnt); end
  endtask

  task test_halt_drain;
    halt_req = 1'b1;
    #1;
    total++; if (ctl !== 8'hAB) begin bad++; $display("FAIL halt_req_ctl got %h want ab", ctl); end
    cyc;
    halt_req = 1'b0;
    #1;
    total++; if (ctl !== 8'h3B || halted !== 1'b0) begin bad++; $display("FAIL drain1 got %h/%b want 3b/0", ctl, halted); end
    cyc;
    dmem_req = 1'b1;
    #1;
    total++; if (ctl !== 8'h00) begin bad++; $display("FAIL drain_freeze got %h want 00", ctl); end
    cyc;
    dmem_req = 1'b0; EX_branch_taken = 1'b1;
    #1;
    total++; if (ctl !== 8'hFF) begin bad++; $display("FAIL drain_branch got %h want ff", ctl); end
    cyc;
    EX_branch_taken = 1'b0;
    #1;
    total++; if (ctl !== 8'h3B) begin bad++; $display("FAIL drain4 got %h want 3b", ctl); end
    cyc;
    #1;
    total++; if (ctl !== 8'h3B || halted !== 1'b0) begin bad++; $display("FAIL drain5 got %h/%b want 3b/0", ctl, halted); end
    cyc;
    #1;
    total++; if (halted !== 1'b1 || ctl !== 8'h00 || stall_cnt !== 7) begin bad++; $display("FAIL halted got %b/%h/%0d want 1/00/7", halted, ctl, stall_cnt); end
    imem_valid = 1'b0;
    cyc;
    #1;
    total++; if (halted !== 1'b1 || stall_cnt !== 7) begin bad++; $display("FAIL halted_hold got %b/%0d want 1/7", halted, stall_cnt); end
    imem_valid = 1'b1; halt_req = 1'b1; resume_req = 1'b1;
    cyc;
    idle;
    #1;
    total++; if (halted !== 1'b0 || ctl !== 8'hAB) begin bad++; $display("FAIL resume got %b/%h want 0/ab", halted, ctl); end
  endtask

  task test_timeout;
    dmem_req = 1'b1;
    cyc;
    cyc;
    cyc;
    #1;
    total++; if (halted !== 1'b0 || dmem_timeout_err !== 1'b0 || ctl !== 8'h00) begin bad++; $display("FAIL pre_timeout got %b/%b/%h want 0/0/00", halted, dmem_timeout_err, ctl); end
    cyc;
    #1;
    total++; if (halted !== 1'b1 || dmem_timeout_err !== 1'b1 || stall_cnt !== 11) begin bad++; $display("FAIL timeout got %b/%b/%0d want 1/1/11", halted, dmem_timeout_err, stall_cnt); end
    dmem_req = 1'b0; resume_req = 1'b1;
    cyc;
    #1;
    total++; if (halted !== 1'b1 || ctl !== 8'h00) begin bad++; $display("FAIL err_no_resume got %b/%h want 1/00", halted, ctl); end
    idle;
  endtask

  task test_reset_mid;
    rst_n = 1'b0;
    cyc;
    rst_n = 1'b1;
    cyc;
    halt_req = 1'b1;
    cyc;
    halt_req = 1'b0;
    #1;
    total++; if (ctl !== 8'h3B) begin bad++; $display("FAIL mid_drain got %h want 3b", ctl); end
    rst_n = 1'b0;
    #1;
    total++; if (ctl !== 8'h14 || halted !== 1'b0 || dmem_timeout_err !== 1'b0) begin bad++; $display("FAIL mid_reset got %h/%b/%b want 14/0/0", ctl, halted, dmem_timeout_err); end
    total++; if (stall_cnt !== 0 || flush_cnt !== 0) begin bad++; $display("FAIL mid_reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    cyc;
    rst_n = 1'b1;
    #1;
    total++; if (ctl !== 8'h14) begin bad++; $display("FAIL mid_boot got %h want 14", ctl); end
    cyc;
    #1;
    total++; if (ctl !== 8'hAB || halted !== 1'b0) begin bad++; $display("FAIL mid_run got %h/%b want ab/0", ctl, halted); end
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_x0;
    test_branch;
    test_bubble;
    test_freeze;
    test_halt_drain;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
